// File: rtl/id_ex_stage_pkg.sv
// Shared core definitions for decode and execute: control-bundle layout,
// register index width, bubble counter width and the ID/EX update actions.
package id_ex_stage_pkg;

  // Width of the control bundle carried from decode into execute
  localparam int CTRL_W = 12;

  // Bit positions inside the control bundle; bits above CTRL_JUMP select ALU/result
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_JUMP      = 4;

  // Architectural register index width (x0..x31)
  localparam int REG_IDX_W = 5;

  // Width of the saturating load-use bubble counter
  localparam int CNT_W = 16;

  // What the ID/EX register does on the next rising edge when not in reset
  typedef enum logic [1:0] {
    UPD_CAPTURE = 2'd0,
    UPD_HOLD    = 2'd1,
    UPD_BUBBLE  = 2'd2,
    UPD_FLUSH   = 2'd3
  } ex_update_e;

  // True when an instruction really reads register src and it equals dst
  function automatic logic src_hits(input logic                 used,
                                    input logic [REG_IDX_W-1:0] src,
                                    input logic [REG_IDX_W-1:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detection between the instruction in decode and a load
// sitting in execute. Purely combinational.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic                 ex_valid,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic                 flush_e,
  input  logic                 ex_stall,
  output logic                 load_use,
  output logic                 stall_fd
);

  // A load into x0 never produces a value, so it can never cause a stall; a flush
  // squashes decode anyway, so front-end freeze is dropped while flushing
  always_comb begin
    load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
               (src_hits(id_rs1_used, id_rs1, ex_rd) ||
                src_hits(id_rs2_used, id_rs2, ex_rd));
    stall_fd = (load_use || ex_stall) && !flush_e;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, hold, load-use bubble insertion and a
// saturating count of inserted load-use bubbles.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = id_ex_stage_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush_e,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              stall_fd,
  output logic [15:0]       bubble_cnt
);

  import id_ex_stage_pkg::*;

  logic             load_use;
  ex_update_e       update;
  logic [CNT_W-1:0] bubble_cnt_q;

  hazard_detect u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEM_READ]),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .flush_e     (flush_e),
    .ex_stall    (ex_stall),
    .load_use    (load_use),
    .stall_fd    (stall_fd)
  );

  // Pick this edge's action: flush beats stall beats load-use beats capture
  always_comb begin
    update = UPD_CAPTURE;
    if (flush_e) begin
      update = UPD_FLUSH;
    end else if (ex_stall) begin
      update = UPD_HOLD;
    end else if (load_use) begin
      update = UPD_BUBBLE;
    end
  end

  // Pipeline register; flush and load-use bubbles both zero every field so a bubble
  // can never write the register file or memory
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_ctrl  <= '0;
    end else begin
      case (update)
        UPD_FLUSH, UPD_BUBBLE: begin
          ex_valid <= 1'b0;
          ex_pc    <= '0;
          ex_rs1   <= '0;
          ex_rs2   <= '0;
          ex_rd    <= '0;
          ex_rd1   <= '0;
          ex_rd2   <= '0;
          ex_imm   <= '0;
          ex_ctrl  <= '0;
        end
        UPD_CAPTURE: begin
          ex_valid <= id_valid;
          ex_pc    <= id_pc;
          ex_rs1   <= id_rs1;
          ex_rs2   <= id_rs2;
          ex_rd    <= id_rd;
          ex_rd1   <= id_rd1;
          ex_rd2   <= id_rd2;
          ex_imm   <= id_imm;
          ex_ctrl  <= id_valid ? id_ctrl : '0;
        end
        default: begin
        end
      endcase
    end
  end

  // Count only load-use bubbles, sticking at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else if ((update == UPD_BUBBLE) && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;

endmodule
